// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add sequencer for the ALU `mul` op: stalls the CPU while it runs
// and presents the low WIDTH product bits. Optional macro: MUL_EARLY_EXIT_EN.
module mul_seq_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CNT_W    = 6,
    parameter logic [3:0]  MUL_CODE = 4'b0101
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_sum;
    logic             accept;
    logic             run_last;

    assign accept  = (state == S_IDLE) && start_i && (ALUCtrl_i == MUL_CODE);
    // Carry out of the add is intentionally dropped: only the low word is kept.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_EXIT_EN
    assign run_last = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
    assign run_last = (cnt == CNT_W'(WIDTH - 1));
`endif

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt == S_RUN);
            done_o <= (state_nxt == S_DONE);
        end
    end

    // Next-state and combinational stall.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall_o   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                stall_o = 1'b1;
                if (run_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift-add datapath; operands are captured only at accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= src1_i;
            mplier <= src2_i;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (run_last) begin
                result_o <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: latency, stall/busy/done shape, products, reset abort.
module tb_mul_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam logic [3:0]  MUL   = 4'b0101;
    localparam logic [3:0]  ADD   = 4'b0010;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_total = 0;
    int n_pass  = 0;

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6), .MUL_CODE(MUL)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .start_i  (start),
        .ALUCtrl_i(alu_ctrl),
        .src1_i   (src1),
        .src2_i   (src2),
        .busy_o   (busy),
        .stall_o  (stall),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Number of RUN edges the sequencer should spend on multiplier b.
    function automatic int run_edges(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int hb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hb = i;
        return hb + 1;
`else
        return 32;
`endif
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit perturb, input string tag);
        int  stall_n;
        int  busy_n;
        int  cyc;
        bit  seen;
        @(negedge clk);
        start = 1'b1; alu_ctrl = MUL; src1 = a; src2 = b;
        #1;
        stall_n = int'(stall);
        busy_n  = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end else begin
                stall_n += int'(stall);
                busy_n  += int'(busy);
                cyc++;
                if (perturb) begin
                    start = cyc[0]; alu_ctrl = MUL;
                    src1 = $urandom; src2 = $urandom;
                end
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stall_n), 32'(run_edges(b) + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(run_edges(b)));
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_ctrl = 4'd0; src1 = '0; src2 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_mul(32'd3, 32'd5, 32'd15, 1'b0, "m3x5");
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, "mffx2");
        run_mul(32'h8000_0000, 32'd2, 32'd0, 1'b0, "movf");
        run_mul(32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0, "mshift");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "mffxff");
        run_mul(32'd7, 32'd9, 32'd63, 1'b1, "m7x9_pert");
        run_mul(32'd7, 32'd1, 32'd7, 1'b0, "m7x1");
        run_mul(32'd5, 32'd0, 32'd0, 1'b0, "m5x0");

        // Result holds across idle cycles.
        run_mul(32'd6, 32'd7, 32'd42, 1'b0, "m6x7");
        repeat (3) @(negedge clk);
        check("hold_result", result, 32'd42);

        // Non-mul code is ignored.
        start = 1'b1; alu_ctrl = ADD; src1 = 32'd1; src2 = 32'd1;
        #1;
        check("add_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("add_busy", 32'(busy), 32'd0);
            check("add_done", 32'(done), 32'd0);
        end
        start = 1'b0;

        // Asynchronous reset at RUN cycle 10 aborts the multiply.
        @(negedge clk);
        start = 1'b1; alu_ctrl = MUL; src1 = 32'd11; src2 = 32'd13;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) check("arst_no_done", 32'(done), 32'd0);
        end
        run_mul(32'd4, 32'd4, 32'd16, 1'b0, "m4x4");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the `mul` operation decoded by the ALU controller (ALU control code 4'b0101).
- Replaces a single-cycle multiply with an iterative shift-add datapath, one multiplier bit per clock.
- Stalls the CPU (PC / register write) while the multiply runs, then presents the low WIDTH bits of the product for write-back.
- Sits beside the ALU; its result is selected into the write-back path when done_o is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.
- MUL_CODE, 4'b0101, ALU control value that identifies a multiply.

Ports:
- clk_i, input, 1, system clock; all state updates on the rising edge.
- rst_i, input, 1, reset, asynchronous, active-low.
- start_i, input, 1, instruction valid / issue strobe from the decode stage.
- ALUCtrl_i, input, 4, ALU control code from the ALU controller.
- src1_i, input, WIDTH, multiplicand (rs).
- src2_i, input, WIDTH, multiplier (rt).
- busy_o, output, 1, sequencer is in RUN.
- stall_o, output, 1, hold PC and suppress register write this cycle.
- done_o, output, 1, one-cycle pulse; result_o is valid.
- result_o, output, WIDTH, low WIDTH bits of src1*src2, unsigned.

Behaviour:
- Reset (rst_i=0, any time, including mid-RUN):
  - state=IDLE; acc, mcand, mplier and cnt cleared.
  - busy_o=0, done_o=0, stall_o=0, result_o=0.
  - Any in-flight multiply is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- Accept condition: state==IDLE && start_i==1 && ALUCtrl_i==MUL_CODE.
- IDLE:
  - On an accepting edge: acc<=0, mcand<=src1_i, mplier<=src2_i, cnt<=0, go to RUN.
  - With start_i=1 and a non-mul code: ignored, stays IDLE, stall_o=0.
- stall_o is combinational:
  - 1 in IDLE when the accept condition holds, so the issuing instruction is held the same cycle.
  - 1 throughout RUN.
  - 0 in DONE and otherwise.
- RUN, on each edge:
  - If mplier[0]=1: acc<=acc+mcand, modulo 2^WIDTH; the carry out is dropped.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: go to DONE and register result_o<=final acc.
- RUN ignores start_i, ALUCtrl_i, src1_i and src2_i; operands are latched only at accept.
- DONE:
  - done_o=1 and busy_o=0 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
  - start_i in DONE is ignored; the CPU issues its next instruction the following cycle.
- Latency (accept edge = edge 0):
  - RUN occupies edges 1..WIDTH.
  - done_o is high in the cycle after edge WIDTH.
  - That is WIDTH+1 cycles of stall-inclusive latency.
- result_o holds its value until the next completed multiply or reset.
- busy_o=1 exactly when state==RUN.
- Products with overflow keep only the low WIDTH bits (MIPS `mul` low word).

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the post-shift multiplier is zero (mplier>>1 == 0), go to DONE on that edge and register the final acc.
  - If src2_i==0 at accept, RUN lasts exactly one edge.
  - Latency becomes (index of highest set bit of src2_i)+2 cycles to done_o.
- Undefined: fixed WIDTH-iteration latency as above.

Test Plan:
- Reset with rst_i=0 for 2 cycles, then release -> all outputs 0, state IDLE.
- start_i=1, ALUCtrl_i=4'b0101, src1=3, src2=5 -> stall_o=1 for 33 cycles, then done_o=1 for exactly 1 cycle with result_o=15. busy_o=1 for 32 cycles.
- src1=32'hFFFFFFFF, src2=2 -> result_o=32'hFFFFFFFE. src1=32'h80000000, src2=2 -> result_o=0 (overflow truncated).
- start_i=1 with ALUCtrl_i=4'b0010 (add) -> stall_o=0, busy_o=0, no done pulse. During RUN, change src1/src2 and toggle start_i -> result unaffected (7*9 yields 63).
- Assert rst_i=0 at RUN cycle 10 -> outputs 0 immediately (asynchronous), no done pulse. A new 4*4 after release -> 16.
- MUL_EARLY_EXIT_EN defined, src2=1, src1=7 -> done_o in cycle 2 after accept, result_o=7. src2=0 -> done_o in cycle 2 after accept, result_o=0.
